// File: rtl/fetch_queue_pkg.sv
// Shared definitions for the dual-issue fetch queue.
package fetch_queue_pkg;

  // Instruction word shown on slots that hold nothing (addi x0,x0,0).
  localparam logic [31:0] FQ_NOP = 32'h00000013;

  // One stored entry: instruction word plus its PC.
  localparam int FQ_ENTRY_W = 64;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
  } fq_entry_t;

endpackage

// File: rtl/fetch_queue_ram.sv
// Entry storage: DEPTH x {inst, pc}, two write ports, two async read ports.
// No reset; the owner masks unoccupied slots through its valid logic.
module fetch_queue_ram
  import fetch_queue_pkg::*;
#(
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic            clock_i,
  input  logic            we0_i,
  input  logic [AW-1:0]   waddr0_i,
  input  fq_entry_t       wdata0_i,
  input  logic            we1_i,
  input  logic [AW-1:0]   waddr1_i,
  input  fq_entry_t       wdata1_i,
  input  logic [AW-1:0]   raddr0_i,
  input  logic [AW-1:0]   raddr1_i,
  output fq_entry_t       rdata0_o,
  output fq_entry_t       rdata1_o
);

  fq_entry_t mem_q [DEPTH];

  // Both write ports always target distinct slots (tail and tail+1).
  always_ff @(posedge clock_i) begin
    if (we0_i) mem_q[waddr0_i] <= wdata0_i;
    if (we1_i) mem_q[waddr1_i] <= wdata1_i;
  end

  assign rdata0_o = mem_q[raddr0_i];
  assign rdata1_o = mem_q[raddr1_i];

endmodule

// File: rtl/fetch_queue.sv
// Dual-issue instruction queue between I-mem fetch and decode.
// Accepts a 64-bit two-instruction packet per cycle, presents the two oldest.
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int          DEPTH = 8,
  parameter logic [31:0] NOP   = FQ_NOP,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic          clock_i,
  input  logic          reset_i,
  input  logic          fetch_valid_i,
  input  logic [31:0]   fetch_pc_i,
  input  logic [63:0]   fetch_data_i,
  output logic          ready_o,
  input  logic          flush_i,
  input  logic [1:0]    deq_i,
  output logic [31:0]   inst0_o,
  output logic [31:0]   inst1_o,
  output logic [31:0]   pc0_o,
  output logic [31:0]   pc1_o,
  output logic          valid0_o,
  output logic          valid1_o,
  output logic [CW-1:0] count_o
);

  logic [AW-1:0] head_q, head_d;
  logic [AW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;

  logic          enq;
  logic          odd;
  logic [CW-1:0] enq_n;
  logic [CW-1:0] deq_req;
  logic [CW-1:0] deq_eff;

  logic          we0, we1;
  fq_entry_t     wdata0, wdata1;
  fq_entry_t     rdata0, rdata1;

  // Space for a full packet; registered count only, so no path from deq_i.
  assign ready_o = (count_q <= CW'(DEPTH - 2));

  // Enqueue/dequeue amounts and next pointer/count values.
  always_comb begin
    odd     = fetch_pc_i[2];
    enq     = fetch_valid_i && ready_o && !flush_i;
    enq_n   = '0;
    if (enq) enq_n = odd ? CW'(1) : CW'(2);
    // deq_i=3 is treated as 2; never pop more than is held.
    deq_req = (deq_i == 2'd0) ? '0 : (deq_i == 2'd1) ? CW'(1) : CW'(2);
    deq_eff = (deq_req > count_q) ? count_q : deq_req;
    head_d  = head_q + AW'(deq_eff);
    tail_d  = tail_q + AW'(enq_n);
    count_d = count_q + enq_n - deq_eff;
  end

  // Write-port steering: an odd-word packet stores only its second instruction.
  always_comb begin
    we0         = enq;
    we1         = enq && !odd;
    wdata0.inst = odd ? fetch_data_i[31:0] : fetch_data_i[63:32];
    wdata0.pc   = fetch_pc_i;
    wdata1.inst = fetch_data_i[31:0];
    wdata1.pc   = fetch_pc_i + 32'd4;
  end

  // Pointer and occupancy state; reset and flush both empty the queue.
  always_ff @(posedge clock_i) begin
    if (reset_i || flush_i) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  fetch_queue_ram #(.DEPTH(DEPTH)) u_ram (
    .clock_i  (clock_i),
    .we0_i    (we0),
    .waddr0_i (tail_q),
    .wdata0_i (wdata0),
    .we1_i    (we1),
    .waddr1_i (tail_q + AW'(1)),
    .wdata1_i (wdata1),
    .raddr0_i (head_q),
    .raddr1_i (head_q + AW'(1)),
    .rdata0_o (rdata0),
    .rdata1_o (rdata1)
  );

  // Issue view: mask slots beyond the occupancy with NOP / pc 0.
  always_comb begin
    valid0_o = (count_q != '0);
    valid1_o = (count_q >= CW'(2));
    inst0_o  = valid0_o ? rdata0.inst : NOP;
    pc0_o    = valid0_o ? rdata0.pc   : 32'd0;
    inst1_o  = valid1_o ? rdata1.inst : NOP;
    pc1_o    = valid1_o ? rdata1.pc   : 32'd0;
  end

  assign count_o = count_q;

endmodule

// File: doc/fetch_queue.md
# fetch_queue

Dual-issue instruction queue between the instruction-memory read port and decode. Each cycle it accepts a 64-bit fetch packet of two 32-bit instructions with its PC, and presents the two oldest instructions with their PCs to decode and issue. It absorbs the case where issue consumes zero, one or two instructions per cycle, and it flushes on redirect. Its ready signal drives the frontend write-enable.

## Interface
- DEPTH, 8, instruction slots (power of two, ≥4)
- NOP, 32'h00000013, instruction word presented on invalid slots

- clock_i  in  1  clock
- reset_i  in  1  synchronous, active-high reset
- fetch_valid_i  in  1  fetch packet present this cycle
- fetch_pc_i  in  32  PC of the packet (word-aligned)
- fetch_data_i  in  64  [63:32] = inst at PC, [31:0] = inst at PC+4
- ready_o  out  1  packet accepted if fetch_valid_i; frontend write-enable
- flush_i  in  1  discard all contents (redirect)
- deq_i  in  2  instructions consumed this cycle (0, 1 or 2)
- inst0_o / inst1_o  out  32  oldest / second-oldest instruction
- pc0_o / pc1_o  out  32  PCs of inst0_o / inst1_o
- valid0_o / valid1_o  out  1  slot holds a real instruction
- count_o  out  $clog2(DEPTH)+1  occupancy

## Operation
- Storage is a circular array of DEPTH {inst, pc} entries with head and tail pointers of $clog2(DEPTH) bits (wrap modulo DEPTH) and a count register.
- Enqueue happens when fetch_valid_i && ready_o && !flush_i.
  - If fetch_pc_i[2]==0, two entries are written: {data[63:32], pc} at tail, then {data[31:0], pc+4} at tail+1. Tail advances by 2.
  - If fetch_pc_i[2]==1 (branch into odd word), one entry is written: {data[31:0], pc}. Tail advances by 1.
- ready_o = (DEPTH − count) ≥ 2. It is computed from registered count only; there is no combinational path from deq_i.
- Dequeue: effective deq = min(deq_i, count). deq_i=3 is treated as 2. Head advances by effective deq.
- Enqueue and dequeue in the same cycle are both honoured: count_next = count + enq_n − deq_eff.
- Outputs are combinational reads of head and head+1 (wrapped).
  - valid0_o = count≥1, valid1_o = count≥2.
  - An invalid slot outputs inst=NOP and pc=0.
- Flush: head, tail and count go to 0. The same-cycle fetch packet and deq_i are ignored. Flush has priority over everything except reset.
- Reset behaves identically to flush. Outputs after reset: valid0_o=0, valid1_o=0, inst0_o=inst1_o=NOP, pc0_o=pc1_o=0, count_o=0, ready_o=1.

## Timing
- Enqueue-to-output latency is one cycle: a packet accepted at edge N is visible at the outputs during the cycle after edge N.
- A queue at count=DEPTH−1 deasserts ready_o. A packet presented while ready_o=0 is not written, and the frontend must hold it.
- Reset or flush asserted mid-stream takes effect at the next edge. The packet presented that cycle is lost, and the frontend re-fetches from the redirect PC.
- Pointer wrap: a two-entry write at tail=DEPTH−1 writes slots DEPTH−1 and 0.

## Structure
- Add to the shared defs: FQ_NOP constant (32'h00000013).
- Add to the shared defs: a fetch-entry width define (64 = inst + pc).
- Sub-module fetch_queue_ram: DEPTH×64 register array with 2 write ports and 2 combinational read ports. Pointer, count and valid logic stay in fetch_queue.

## Test plan
- Reset, then a packet at pc=0x100 with data={A,B}: the next cycle shows inst0=A, pc0=0x100, inst1=B, pc1=0x104, both valid, count=2.
- Enqueue 0x100, 0x108, 0x110 with deq=0: count=6 and ready_o=1. One more packet gives count=8 and ready_o=0. A packet held while ready_o=0 leaves count unchanged.
- Alternating deq=1 with continuous enqueue: verify in-order PCs 0x100, 0x104, 0x108… across head/tail wrap.
- Packet with pc=0x204: one entry {data[31:0], 0x204} is written and count increments by 1.
- deq_i=2 with count=1: count becomes 0, valid0 drops, and the outputs show NOP/0.
- flush_i asserted with count=5 and a simultaneous packet: the next cycle shows count=0, both valids low and ready_o=1. Repeat the same check with reset_i.
